sp_result_drain: RTL and testbench

SP_RESULT_DRAIN -- requirements
Module: sp_result_drain

---
 rtl/sp_result_drain.sv | 187 ++++++++++++++++++
 tb/tb_sp_result_drain.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sp_result_drain.sv
// sp_result_drain
// Drains a block of 64-bit result words out of a scratchpad BRAM and
// presents them on a valid/ready stream, accumulating an XOR checksum.
//
// Ports:
//   clk, rst        - rising-edge clock, synchronous active-high reset
//   start           - one-cycle drain request, only honoured in IDLE
//   base_addr       - first BRAM address (captured on accepted start)
//   word_cnt        - number of words to drain (captured on accepted start)
//   raddr, rd_issue - BRAM read request; rdata returns one cycle after
//   rdata           - BRAM read data
//   busy            - drain in progress (cycle after start through done)
//   done            - one-cycle pulse after the final word is accepted
//   out_valid, out_data, out_ready - result stream
//   checksum        - XOR of every word transferred in the current/last drain
//   fsm_state       - current controller state, for observation
//
// Stream handshake: a word transfers on every rising edge where
// out_valid && out_ready; while out_valid && !out_ready, out_data holds.
//
// The first read is issued combinationally in the same cycle start is
// accepted, so the first word reaches the output buffer two cycles after
// start and the final done pulse lands N+2 cycles after start.
module sp_result_drain #(
    parameter int unsigned ADDR_STEP  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic [15:0] word_cnt,
    output logic [31:0] raddr,
    output logic        rd_issue,
    input  logic [63:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        out_valid,
    output logic [63:0] out_data,
    input  logic        out_ready,
    output logic [63:0] checksum,
    output logic [1:0]  fsm_state
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [31:0]      raddr_q;
    logic [31:0]      next_addr_q;
    logic [31:0]      issue_addr;
    logic [15:0]      cnt_q;
    logic [15:0]      issued_q;
    logic             inflight_q;
    logic [63:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] fifo_count_q;
    logic [63:0]      checksum_q;

    logic accept;
    logic issue;
    logic credit_ok;
    logic fire;
    logic fifo_wr;

    assign accept    = (state_q == IDLE) && start;
    // Buffered words plus the one word that may still be on its way back
    // from the BRAM must leave room, so a returning word always has a slot.
    assign credit_ok = (fifo_count_q + CNT_W'(inflight_q)) < CNT_W'(FIFO_DEPTH);
    assign out_valid = (fifo_count_q != '0);
    assign out_data  = mem[rd_ptr_q];
    assign fire      = out_valid && out_ready;
    // Only reads issued since the last reset are marked in flight, so data
    // returning after an aborting reset is never written.
    assign fifo_wr   = inflight_q;

    always_comb begin
        state_d    = state_q;
        issue      = 1'b0;
        issue_addr = next_addr_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (word_cnt != 16'd0) begin
                        issue      = 1'b1;
                        issue_addr = base_addr;
                        state_d    = RUN;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                if ((issued_q != cnt_q) && credit_ok) begin
                    issue = 1'b1;
                end
                if ((issued_q + 16'(issue)) == cnt_q) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                // Final word leaving with nothing else buffered or returning.
                if (fire && (fifo_count_q == CNT_W'(1)) && !inflight_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rd_issue  = issue;
    assign raddr     = issue ? issue_addr : raddr_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign checksum  = checksum_q;
    assign fsm_state = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            raddr_q      <= '0;
            next_addr_q  <= '0;
            cnt_q        <= '0;
            issued_q     <= '0;
            inflight_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
            checksum_q   <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= issue;

            if (issue) begin
                raddr_q     <= issue_addr;
                next_addr_q <= issue_addr + 32'(ADDR_STEP);
            end

            if (accept) begin
                cnt_q    <= word_cnt;
                issued_q <= (word_cnt != 16'd0) ? 16'd1 : 16'd0;
            end else if (issue) begin
                issued_q <= issued_q + 16'd1;
            end

            if (fifo_wr) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (fire) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({fifo_wr, fire})
                2'b10:   fifo_count_q <= fifo_count_q + CNT_W'(1);
                2'b01:   fifo_count_q <= fifo_count_q - CNT_W'(1);
                default: fifo_count_q <= fifo_count_q;
            endcase

            if (accept) begin
                checksum_q <= '0;
            end else if (fire) begin
                checksum_q <= checksum_q ^ out_data;
            end
        end
    end

    // Storage array carries no reset; pointers and count define validity.
    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            mem[wr_ptr_q] <= rdata;
        end
    end

endmodule

// File: tb/tb_sp_result_drain.sv
module tb_sp_result_drain;

    localparam int STEP  = 1;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] word_cnt;
    logic [31:0] raddr;
    logic        rd_issue;
    logic [63:0] rdata;
    logic        busy;
    logic        done;
    logic        out_valid;
    logic [63:0] out_data;
    logic        out_ready;
    logic [63:0] checksum;
    logic [1:0]  fsm_state;

    always #5 clk = ~clk;

    sp_result_drain #(.ADDR_STEP(STEP), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .word_cnt(word_cnt), .raddr(raddr), .rd_issue(rd_issue),
        .rdata(rdata), .busy(busy), .done(done), .out_valid(out_valid),
        .out_data(out_data), .out_ready(out_ready), .checksum(checksum),
        .fsm_state(fsm_state)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    logic [63:0] exp_q [$];
    logic [31:0] addr_q [$];
    logic [63:0] exp_chk;
    logic [31:0] salt = 32'h0;

    // BRAM model: word content derived from its address.
    function automatic logic [63:0] word_of(input logic [31:0] a);
        return {salt, a};
    endfunction

    always @(posedge clk) begin
        if (rd_issue) rdata <= word_of(raddr);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor state
    logic        mon_en = 1'b0;
    int          done_cnt, done_cyc, first_valid_cyc, issue_cnt, start_cyc;
    logic        saw_valid;
    logic        prev_stall;
    logic [63:0] prev_data;

    always @(negedge clk) begin
        if (mon_en) begin
            if (rd_issue) begin
                issue_cnt++;
                chk("issue_expected", 64'(addr_q.size() != 0), 64'd1);
                if (addr_q.size() != 0) chk("raddr", 64'(raddr), 64'(addr_q.pop_front()));
            end
            if (out_valid) begin
                saw_valid = 1'b1;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
            end
            if (prev_stall) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_data", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                chk("out_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) chk("out_data", out_data, exp_q.pop_front());
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] b, input logic [15:0] n);
        logic [31:0] a;
        done_cnt        = 0;
        issue_cnt       = 0;
        first_valid_cyc = -1;
        saw_valid       = 1'b0;
        prev_stall      = 1'b0;
        exp_chk         = '0;
        for (int k = 0; k < int'(n); k++) begin
            a = b + 32'(k * STEP);
            addr_q.push_back(a);
            exp_q.push_back(word_of(a));
            exp_chk ^= word_of(a);
        end
        base_addr = b;
        word_cnt  = n;
        start     = 1'b1;
        start_cyc = cyc;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int i;
        i = 0;
        while (done_cnt == 0 && i < budget) begin
            tick();
            i++;
        end
        chk(tag, 64'(done_cnt != 0), 64'd1);
    endtask

    task automatic check_drained(input string tag);
        chk({tag, "_checksum"}, checksum, exp_chk);
        chk({tag, "_exp_left"}, 64'(exp_q.size()), 64'd0);
        chk({tag, "_addr_left"}, 64'(addr_q.size()), 64'd0);
        chk({tag, "_busy_after"}, 64'(busy), 64'd0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        word_cnt  = '0;
        out_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        chk("rst_raddr", 64'(raddr), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_checksum", checksum, 64'd0);
        chk("rst_state", 64'(fsm_state), 64'd0);
        mon_en = 1'b1;

        // Basic 4-word drain, word = address, checksum cancels to zero
        salt = 32'h0;
        out_ready = 1'b1;
        do_start(32'h100, 16'd4);
        chk("t1_busy", 64'(busy), 64'd1);
        wait_done(50, "t1_done_seen");
        chk("t1_done_lat", 64'(done_cyc - start_cyc), 64'd6);
        chk("t1_valid_lat", 64'(first_valid_cyc - start_cyc), 64'd2);
        check_drained("t1");

        // Back-pressure: reads stall at buffer depth, nothing lost
        salt = 32'h5A5A_0000;
        out_ready = 1'b0;
        do_start(32'h2000, 16'd8);
        repeat (9) tick();
        chk("t2_issued_stalled", 64'(issue_cnt), 64'(DEPTH));
        chk("t2_valid_stalled", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        wait_done(50, "t2_done_seen");
        chk("t2_issued_total", 64'(issue_cnt), 64'd8);
        check_drained("t2");

        // Zero-length drain
        do_start(32'h300, 16'd0);
        wait_done(10, "t3_done_seen");
        chk("t3_done_lat", 64'(done_cyc - start_cyc), 64'd1);
        chk("t3_no_issue", 64'(issue_cnt), 64'd0);
        chk("t3_no_valid", 64'(saw_valid), 64'd0);
        check_drained("t3");

        // Address wrap-around
        salt = $urandom;
        do_start(32'hFFFF_FFFE, 16'd3);
        wait_done(50, "t4_done_seen");
        chk("t4_done_lat", 64'(done_cyc - start_cyc), 64'd5);
        check_drained("t4");

        // Reset in the middle of a long drain
        salt = 32'hC0DE_0000;
        do_start(32'h4000, 16'd16);
        repeat (2) tick();
        mon_en = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_raddr", 64'(raddr), 64'd0);
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_done", 64'(done), 64'd0);
        chk("t5_valid", 64'(out_valid), 64'd0);
        chk("t5_checksum", checksum, 64'd0);
        chk("t5_state", 64'(fsm_state), 64'd0);
        tick();
        chk("t5_discard_valid", 64'(out_valid), 64'd0);
        chk("t5_discard_done", 64'(done), 64'd0);
        exp_q.delete();
        addr_q.delete();
        mon_en = 1'b1;
        salt = 32'h1357_0000;
        do_start(32'h5000, 16'd2);
        wait_done(50, "t5b_done_seen");
        check_drained("t5b");

        // Long drain with random back-pressure and an ignored second start
        salt = $urandom;
        do_start(32'h8000, 16'd200);
        for (int i = 0; i < 3000 && done_cnt == 0; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            if (i == 50) begin
                base_addr = 32'hDEAD_0000;
                word_cnt  = 16'd5;
                start     = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        out_ready = 1'b1;
        chk("t6_done_seen", 64'(done_cnt != 0), 64'd1);
        repeat (5) tick();
        chk("t6_one_done", 64'(done_cnt), 64'd1);
        chk("t6_issued", 64'(issue_cnt), 64'd200);
        check_drained("t6");

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
